input_channel_buffer: RTL

INPUT_CHANNEL_BUFFER -- requirements
Module: input_channel_buffer

---
 rtl/input_channel_buffer_pkg.sv | 42 ++++
 rtl/input_channel_buffer_ram.sv | 23 ++
 rtl/input_channel_buffer.sv | 98 +++++++++
 3 files changed

// File: rtl/input_channel_buffer_pkg.sv
// Shared flit/buffer parameters, types and pointer helper for input_channel_buffer.
// Optional feature macro: PARITY_CHECK_EN (per-entry even-parity storage and head check).
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef BUFFERSIZE
`define BUFFERSIZE 4
`endif
`ifndef BUFFERSIZE_WIDTH
`define BUFFERSIZE_WIDTH 3
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef BODY
`define BODY 2'b11
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif

package input_channel_buffer_pkg;

  localparam int FLIT_W = `FLIT_WIDTH;
  localparam int DEPTH  = `BUFFERSIZE;
  localparam int CNT_W  = `BUFFERSIZE_WIDTH;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    FLIT_TAIL = `TAIL,
    FLIT_BODY = `BODY,
    FLIT_HEAD = `HEAD
  } flit_type_e;

  typedef logic [FLIT_W-1:0] flit_t;

  // Explicit wrap keeps non-power-of-two depths inside the storage range.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/input_channel_buffer_ram.sv
// Flit storage for input_channel_buffer: one synchronous write port, one asynchronous read port.
module buffer_ram #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [WIDTH-1:0]  read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/input_channel_buffer.sv
// Router input-channel FIFO with first-word-fall-through head, credit count and sticky error flags.
// Optional feature macro: PARITY_CHECK_EN.
module input_channel_buffer
  import input_channel_buffer_pkg::*;
#(
  parameter int P_LOCAL_ID      = 0,
  parameter int P_LOCAL_CHANNEL = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              command_write,
  input  logic [FLIT_W-1:0] data_in,
  input  logic              data_in_parity,
  input  logic              command_read,
  output logic [FLIT_W-1:0] data_out,
  output logic [CNT_W-1:0]  buffer_credits_local,
  output logic              error_ecc,
  output logic              overflow,
  output logic              underflow
);

`ifdef PARITY_CHECK_EN
  localparam int ENTRY_W = FLIT_W + 1;
`else
  localparam int ENTRY_W = FLIT_W;
`endif

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic               empty;
  logic               full;
  logic               wr_accept;
  logic               rd_accept;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign rd_accept = command_read && !empty;
  // A full buffer still takes a write when the head is popped in the same cycle.
  assign wr_accept = command_write && (!full || command_read);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      count                <= '0;
      buffer_credits_local <= CNT_W'(DEPTH);
      overflow             <= 1'b0;
      underflow            <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= next_ptr(wr_ptr);
      if (rd_accept) rd_ptr <= next_ptr(rd_ptr);
      if (wr_accept != rd_accept) begin
        count                <= wr_accept ? count + 1'b1 : count - 1'b1;
        buffer_credits_local <= wr_accept ? buffer_credits_local - 1'b1
                                          : buffer_credits_local + 1'b1;
      end
      if (command_write && full && !command_read) overflow <= 1'b1;
      if (command_read && empty) underflow <= 1'b1;
    end
  end

  buffer_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_buffer_ram (
    .CLK       (CLK),
    .write_en  (wr_accept),
    .write_addr(wr_ptr),
    .write_data(wr_entry),
    .read_addr (rd_ptr),
    .read_data (rd_entry)
  );

  assign data_out = empty ? '0 : rd_entry[FLIT_W-1:0];

`ifdef PARITY_CHECK_EN
  assign wr_entry  = {data_in_parity, data_in};
  assign error_ecc = !empty && (rd_entry[FLIT_W] != ^rd_entry[FLIT_W-1:0]);
`else
  logic unused_parity;
  assign unused_parity = data_in_parity;
  assign wr_entry      = data_in;
  assign error_ecc     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (count <= CNT_W'(DEPTH))
        else $error("router %0d channel %0d: occupancy %0d exceeds depth",
                    P_LOCAL_ID, P_LOCAL_CHANNEL, count);
    end
  end

endmodule
